// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output (ovf).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, borrow_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             d_bit, br_d;

  // Full-subtractor cell on the current LSB pair and the chained borrow.
  assign d_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            borrow_q    <= br_d;
            out_valid_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q       <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule
